// File: rtl/trap_filter_cfg.sv
// trap_filter_cfg: runtime-configurable trapezoidal (k,l,M) shaping filter.
// Seven register stages from sample strobe to output, each with its own valid bit.
// Configuration (k, l, M, shift) is validated on cfg_load. An accepted load soft-clears all filter state.
// Optional build macro TRAP_FILTER_SAT_EN: out-of-range results clamp. Without it they wrap.
module trap_filter_cfg #(
  parameter int SIZE_ADC_DATA    = 12,
  parameter int SIZE_FILTER_DATA = 16,
  parameter int MAX_DELAY        = 64,
  parameter int M_W              = 10,
  parameter int K_DEF            = 4,
  parameter int L_DEF            = 8,
  parameter int M_DEF            = 0,
  parameter int SHIFT_DEF        = 7
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [SIZE_ADC_DATA-1:0]             input_data,
  input  logic                                 in_valid,
  input  logic [$clog2(MAX_DELAY+1)-1:0]       cfg_k,
  input  logic [$clog2(MAX_DELAY+1)-1:0]       cfg_l,
  input  logic [M_W-1:0]                       cfg_m,
  input  logic [4:0]                           cfg_shift,
  input  logic                                 cfg_load,
  output logic                                 cfg_err,
  output logic [SIZE_FILTER_DATA-1:0]          output_data,
  output logic                                 out_valid,
  output logic                                 out_ovf
);

  localparam int DW    = $clog2(MAX_DELAY+1);
  localparam int ACC_W = 2*SIZE_ADC_DATA+3;
  localparam int OW    = SIZE_FILTER_DATA;

  logic [DW-1:0]            k_q, l_q, kl_q;
  logic [M_W-1:0]           m_q;
  logic [4:0]               shift_q;
  logic [DW:0]              cnt_q;
  logic [SIZE_ADC_DATA-1:0] d_q [0:MAX_DELAY];
  logic [5:0]               vld_q, prm_q;
  logic signed [ACC_W-1:0]  dk_q, dl_q, dkl_q, p_q, mdkl_q, r_q, s_q;

  logic [DW:0]              kl_sum;
  logic                     cfg_ok, load_ok, accept, primed;
  logic signed [ACC_W-1:0]  m_ext, sh;
  logic [ACC_W-OW:0]        sh_top;
  logic                     ovf;
  logic [OW-1:0]            shaped;

  function automatic logic signed [ACC_W-1:0] ext(input logic [SIZE_ADC_DATA-1:0] x);
    return signed'(ACC_W'(x));
  endfunction

  assign kl_sum  = {1'b0, cfg_k} + {1'b0, cfg_l};
  assign cfg_ok  = (cfg_k != '0) && (cfg_k <= cfg_l) &&
                   (int'(kl_sum) <= MAX_DELAY) && (int'(cfg_shift) < ACC_W);
  assign load_ok = cfg_load & cfg_ok;
  // A rejected load does not block the sample. An accepted one drops it.
  assign accept  = in_valid & ~load_ok;
  // Tag is set on the sample that brings the accepted count to k+l+1.
  assign primed  = (cnt_q >= {1'b0, kl_q});
  assign m_ext   = signed'(ACC_W'(m_q));
  assign sh      = s_q >>> shift_q;
  assign sh_top  = sh[ACC_W-1:OW-1];
  assign ovf     = !((&sh_top) || !(|sh_top));

  // Output shaping of the final accumulator: saturate or wrap to output width
  always_comb begin
    shaped = sh[OW-1:0];
`ifdef TRAP_FILTER_SAT_EN
    if (ovf) shaped = sh[ACC_W-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
`endif
  end

  // Configuration registers, load-reject pulse and priming counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q     <= DW'(K_DEF);
      l_q     <= DW'(L_DEF);
      kl_q    <= DW'(K_DEF + L_DEF);
      m_q     <= M_W'(M_DEF);
      shift_q <= 5'(SHIFT_DEF);
      cnt_q   <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_load & ~cfg_ok;
      if (load_ok) begin
        k_q     <= cfg_k;
        l_q     <= cfg_l;
        kl_q    <= kl_sum[DW-1:0];
        m_q     <= cfg_m;
        shift_q <= cfg_shift;
        cnt_q   <= '0;
      end else if (accept && (cnt_q != ({1'b0, kl_q} + (DW+1)'(1)))) begin
        cnt_q <= cnt_q + (DW+1)'(1);
      end
    end
  end

  // Delay line and seven-stage filter pipeline. An accepted load acts as a synchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i <= MAX_DELAY; i++) d_q[i] <= '0;
      vld_q       <= '0;
      prm_q       <= '0;
      dk_q        <= '0;
      dl_q        <= '0;
      dkl_q       <= '0;
      p_q         <= '0;
      mdkl_q      <= '0;
      r_q         <= '0;
      s_q         <= '0;
      output_data <= '0;
      out_valid   <= 1'b0;
      out_ovf     <= 1'b0;
    end else if (load_ok) begin
      for (int unsigned i = 0; i <= MAX_DELAY; i++) d_q[i] <= '0;
      vld_q       <= '0;
      prm_q       <= '0;
      dk_q        <= '0;
      dl_q        <= '0;
      dkl_q       <= '0;
      p_q         <= '0;
      mdkl_q      <= '0;
      r_q         <= '0;
      s_q         <= '0;
      output_data <= '0;
      out_valid   <= 1'b0;
      out_ovf     <= 1'b0;
    end else begin
      // S1
      if (accept) begin
        d_q[0] <= input_data;
        for (int unsigned i = 1; i <= MAX_DELAY; i++) d_q[i] <= d_q[i-1];
      end
      vld_q <= {vld_q[4:0], accept};
      prm_q <= {prm_q[4:0], accept & primed};
      // S2..S5: combinational stages are registered freely; only accumulators honour valid
      dk_q   <= ext(d_q[0]) - ext(d_q[k_q]);
      dl_q   <= ext(d_q[l_q]) - ext(d_q[kl_q]);
      dkl_q  <= dk_q - dl_q;
      if (vld_q[2]) p_q <= p_q + dkl_q;
      mdkl_q <= dkl_q * m_ext;
      r_q    <= p_q + mdkl_q;
      // S6
      if (vld_q[4]) s_q <= s_q + r_q;
      // S7
      if (vld_q[5]) output_data <= shaped;
      out_valid <= vld_q[5] & prm_q[5];
      out_ovf   <= vld_q[5] & prm_q[5] & ovf;
    end
  end

endmodule

// File: tb/tb_trap_filter_cfg.sv
// Self-checking bench for trap_filter_cfg.
// Randomized stimulus is compared against a sample-domain reference model of the trapezoid recurrences.
module tb_trap_filter_cfg;

  localparam int ADC_W = 12;
  localparam int OUT_W = 16;
  localparam int MAXD  = 64;
  localparam int MW    = 10;
  localparam int ACCW  = 2*ADC_W+3;
  localparam int KW    = $clog2(MAXD+1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [ADC_W-1:0] input_data = '0;
  logic             in_valid = 1'b0;
  logic [KW-1:0]    cfg_k = '0, cfg_l = '0;
  logic [MW-1:0]    cfg_m = '0;
  logic [4:0]       cfg_shift = '0;
  logic             cfg_load = 1'b0;
  logic             cfg_err;
  logic [OUT_W-1:0] output_data;
  logic             out_valid, out_ovf;

  always #5 clk = ~clk;

  trap_filter_cfg #(
    .SIZE_ADC_DATA(ADC_W), .SIZE_FILTER_DATA(OUT_W), .MAX_DELAY(MAXD), .M_W(MW),
    .K_DEF(4), .L_DEF(8), .M_DEF(0), .SHIFT_DEF(7)
  ) dut (
    .clk(clk), .reset(reset), .input_data(input_data), .in_valid(in_valid),
    .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m), .cfg_shift(cfg_shift),
    .cfg_load(cfg_load), .cfg_err(cfg_err), .output_data(output_data),
    .out_valid(out_valid), .out_ovf(out_ovf)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle)", tag, got, exp);
  endtask

  // Reference model: configuration, sample history (newest first) and accumulators.
  int      mk, ml, mm, msh, mcnt;
  int      hist[$];
  longint  mp, ms;
  // Expected outputs, indexed by the clock edge at which they appear.
  bit      ev[16];
  bit      eo[16];
  bit      ee[16];
  longint  ed[16];
  int      cyc = 0;
  longint  last_data = 0;
  int      ovf_seen = 0;

  function automatic longint wrap_acc(input longint v);
    longint m;
    m = v & ((longint'(1) << ACCW) - 1);
    if (m >= (longint'(1) << (ACCW-1))) m -= (longint'(1) << ACCW);
    return m;
  endfunction

  function automatic longint xh(input int j);
    return (j < hist.size()) ? longint'(hist[j]) : 0;
  endfunction

  function automatic void model_clear();
    hist.delete();
    mp = 0; ms = 0; mcnt = 0;
    for (int i = 0; i < 16; i++) begin ev[i] = 0; eo[i] = 0; ee[i] = 0; ed[i] = 0; end
  endfunction

  function automatic void model_edge(input bit v, input int x, input bit ld,
                                     input int k, input int l, input int m, input int sh);
    int     c, slot;
    bit     take;
    longint dkl, r, y, t;
    c = cyc + 1;
    take = v;
    if (ld) begin
      if (k >= 1 && k <= l && k + l <= MAXD && sh < ACCW) begin
        mk = k; ml = l; mm = m; msh = sh;
        model_clear();
        take = 0;
      end else begin
        ee[c % 16] = 1;
      end
    end
    if (take) begin
      hist.push_front(x);
      if (hist.size() > MAXD + 1) void'(hist.pop_back());
      mcnt++;
      dkl = xh(0) - xh(mk) - xh(ml) + xh(mk + ml);
      mp  = wrap_acc(mp + dkl);
      r   = wrap_acc(mp + longint'(mm) * dkl);
      ms  = wrap_acc(ms + r);
      if (mcnt >= mk + ml + 1) begin
        y = ms >>> msh;
        slot = (c + 6) % 16;
        ev[slot] = 1;
        eo[slot] = (y > 32767) || (y < -32768);
`ifdef TRAP_FILTER_SAT_EN
        t = (y > 32767) ? 32767 : (y < -32768) ? -32768 : y;
`else
        t = y & 64'hFFFF;
        if (t >= 32768) t -= 65536;
`endif
        ed[slot] = t;
      end
    end
  endfunction

  task automatic check_cycle();
    int s;
    s = cyc % 16;
    check_val("out_valid", out_valid, ev[s]);
    check_val("cfg_err", cfg_err, ee[s]);
    if (ev[s]) begin
      check_val("output_data", longint'($signed(output_data)), ed[s]);
      check_val("out_ovf", out_ovf, eo[s]);
    end
    if (out_valid) begin
      last_data = longint'($signed(output_data));
      if (out_ovf) ovf_seen++;
    end
    ev[s] = 0; eo[s] = 0; ee[s] = 0;
  endtask

  task automatic tick(input bit v, input int x, input bit ld,
                      input int k, input int l, input int m, input int sh);
    in_valid   = v;
    input_data = ADC_W'(x);
    cfg_load   = ld;
    cfg_k      = KW'(k);
    cfg_l      = KW'(l);
    cfg_m      = MW'(m);
    cfg_shift  = 5'(sh);
    model_edge(v, x, ld, k, l, m, sh);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic samp(input bit v, input int x);
    tick(v, x, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_output_data", output_data, 0);
    check_val("rst_out_ovf", out_ovf, 0);
    check_val("rst_cfg_err", cfg_err, 0);
    mk = 4; ml = 8; mm = 0; msh = 7;
    model_clear();
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step_run(input int amp);
    for (int i = 0; i < 20; i++) samp(1'b1, 0);
    for (int i = 0; i < 30; i++) samp(1'b1, amp);
    for (int i = 0; i < 8; i++) samp(1'b0, 0);
  endtask

  initial begin
    int first;
    #2;
    do_reset();

    // Default configuration, random data, continuous strobe
    for (int i = 0; i < 40; i++) samp(1'b1, int'($urandom_range(0, 4095)));

    // Reset in the middle of a continuous stream, then priming latency
    do_reset();
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      samp(1'b1, int'($urandom_range(0, 4095)));
      if (out_valid && first < 0) first = i;
    end
    check_val("prime_latency", first, 19);

    // Step response, shift 0 then shift 5
    tick(1'b0, 0, 1'b1, 4, 8, 0, 0);
    step_run(100);
    check_val("step_settle_s0", last_data, 3200);
    tick(1'b0, 0, 1'b1, 4, 8, 0, 5);
    step_run(100);
    check_val("step_settle_s5", last_data, 100);

    // Same step with the strobe on every third cycle
    tick(1'b0, 0, 1'b1, 4, 8, 0, 5);
    for (int i = 0; i < 50; i++) begin
      samp(1'b1, (i < 20) ? 0 : 100);
      samp(1'b0, 0);
      samp(1'b0, 0);
    end
    check_val("step_sparse", last_data, 100);

    // Rejected loads in a live stream, with coincident samples
    for (int i = 0; i < 30; i++) begin
      case (i)
        5:  tick(1'b1, 1000, 1'b1, 10, 5, 3, 2);
        11: tick(1'b1, 2000, 1'b1, 33, 32, 3, 2);
        17: tick(1'b0, 0, 1'b1, 0, 4, 3, 2);
        23: tick(1'b1, 3000, 1'b1, 2, 3, 3, 27);
        default: samp(1'(i % 2), int'($urandom_range(0, 4095)));
      endcase
    end

    // Accepted load coincident with a sample
    for (int i = 0; i < 20; i++) samp(1'b1, int'($urandom_range(0, 4095)));
    tick(1'b1, 4000, 1'b1, 3, 6, 5, 2);
    for (int i = 0; i < 30; i++) samp(1'b1, int'($urandom_range(0, 4095)));

    // Large step with maximum pole-zero multiplier
    tick(1'b0, 0, 1'b1, 4, 8, 1023, 0);
    ovf_seen = 0;
    for (int i = 0; i < 5; i++) samp(1'b1, 0);
    for (int i = 0; i < 40; i++) samp(1'b1, 4095);
    for (int i = 0; i < 8; i++) samp(1'b0, 0);
    check_val("ovf_seen", ovf_seen > 0, 1);
`ifdef TRAP_FILTER_SAT_EN
    check_val("ovf_final", last_data, 32767);
`else
    check_val("ovf_final", last_data, -32);
`endif

    // Random mix of strobes, data and (sometimes invalid) configurations
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0)
        tick(1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)), 1'b1,
             int'($urandom_range(0, 12)), int'($urandom_range(0, 40)),
             int'($urandom_range(0, 1023)), int'($urandom_range(0, 30)));
      else
        samp(1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)));
    end
    for (int i = 0; i < 8; i++) samp(1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
